// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the M-extension execute unit: funct3/funct7 op codes
// and the control FSM state encoding.
package ex_muldiv_pkg;

  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iteration datapath shared by shift-add multiply and restoring
// divide on unsigned magnitudes; acc holds {hi, lo} of product or {rem, quo}.
module muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc_q, acc_nx;
  logic [XLEN-1:0]   opnd_q;
  logic [CW-1:0]     cnt_q;
  logic              div_q;

  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     add_a, add_b;
  logic              cin;
  logic [XLEN+1:0]   sum;

  // One adder serves both: hi + multiplicand, or trial subtract of the divisor
  always_comb begin
    hi  = acc_q[2*XLEN-1:XLEN];
    lo  = acc_q[XLEN-1:0];
    if (div_q) begin
      add_a = {hi, lo[XLEN-1]};
      add_b = ~{1'b0, opnd_q};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, hi};
      add_b = lo[0] ? {1'b0, opnd_q} : '0;
      cin   = 1'b0;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + (XLEN+2)'(cin);
    if (div_q) begin
      // carry out set means no borrow: keep the difference, quotient bit 1
      if (sum[XLEN+1]) acc_nx = {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else             acc_nx = {add_a[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {sum[XLEN:0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= div_mode ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      opnd_q <= div_mode ? mag_b : mag_a;
      div_q  <= div_mode;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q  <= acc_nx;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CW'(XLEN-1));

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV M-extension multiply/divide unit: operand sign handling,
// special-case detection and the IDLE/RUN/DONE control FSM.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            input_valid,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] res,
  output logic [31:0]     inst_out
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;
  logic   busy_q;
  logic   accept, step;

  logic [31:0]     inst_q;
  logic [XLEN-1:0] a_q;
  logic            neg_a_q, neg_b_q, dz_q, ovf_q;

  logic [2:0]      f3_in, f3_q;
  logic            sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic            dz_in, ovf_in, special_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quo, rem, quo_s, rem_s, result;
  logic              iter_last;

  // Operand decode on the request side; all of it is latched at accept
  always_comb begin
    f3_in      = inst_in[14:12];
    sgn_a_in   = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                 (f3_in == F3_DIV)  || (f3_in == F3_REM);
    sgn_b_in   = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
    neg_a_in   = sgn_a_in && a[XLEN-1];
    neg_b_in   = sgn_b_in && b[XLEN-1];
    mag_a_in   = neg_a_in ? -a : a;
    mag_b_in   = neg_b_in ? -b : b;
    dz_in      = f3_is_div(f3_in) && (b == '0);
    ovf_in     = ((f3_in == F3_DIV) || (f3_in == F3_REM)) && (a == XMIN) && (b == '1);
    special_in = dz_in || ovf_in;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: if (input_valid) begin
        accept  = 1'b1;
        state_d = ((EARLY_OUT != 0) && special_in) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        step = 1'b1;
        if (iter_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      inst_q  <= '0;
      a_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if (accept) begin
        inst_q  <= inst_in;
        a_q     <= a;
        neg_a_q <= neg_a_in;
        neg_b_q <= neg_b_in;
        dz_q    <= dz_in;
        ovf_q   <= ovf_in;
      end
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (step),
    .div_mode (f3_is_div(f3_in)),
    .mag_a    (mag_a_in),
    .mag_b    (mag_b_in),
    .acc      (acc),
    .last     (iter_last)
  );

  // Sign fix-up and special-case override applied on the DONE cycle
  always_comb begin
    f3_q  = inst_q[14:12];
    prod  = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quo   = acc[XLEN-1:0];
    rem   = acc[2*XLEN-1:XLEN];
    quo_s = (neg_a_q ^ neg_b_q) ? -quo : quo;
    rem_s = neg_a_q ? -rem : rem;
    if (dz_q) begin
      quo_s = '1;
      rem_s = a_q;
    end
    if (ovf_q) begin
      quo_s = XMIN;
      rem_s = '0;
    end
    case (f3_q)
      F3_MUL:                             result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:       result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                    result = quo_s;
      default:                            result = rem_s;
    endcase
  end

  assign busy      = busy_q;
  assign res_valid = (state_q == ST_DONE);
  assign res       = res_valid ? result : '0;
  assign inst_out  = res_valid ? inst_q : '0;

endmodule
